huc3_rtc_bk_ctrl: RTL and testbench

Sequences backup-RAM transfers of HuC3 RTC state between the mapper's RTC registers and the save-file backing memory. On save it snapshots the live timestamp and saved-time values and writes them as 16-bit words. On load it reads the words back and replays them into the mapper's bk_rtc_wr/bk_addr/bk_data port, ending with the word-5 trigger. It sits between the HuC3 mapper, the save/load control logic and the backup-RAM port, and arbitrates save vs load access to that port.

---
 rtl/huc3_rtc_bk_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_huc3_rtc_bk_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huc3_rtc_bk_ctrl.sv
// HuC3 RTC backup-RAM save/load sequencer between mapper RTC registers and save memory.
// Optional build macro HUC3_RTC_CHECKSUM_EN adds a checksum word 6 and a sticky integrity error.
`timescale 1ns/1ps

module huc3_rtc_bk_ctrl #(
    parameter int unsigned       ADDR_W   = 17,
    parameter logic [ADDR_W-1:0] RTC_BASE = '0
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              save_req,
    input  logic              load_req,
    input  logic [31:0]       rtc_timestamp,
    input  logic [47:0]       rtc_savedtime,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              bk_rtc_wr,
    output logic [16:0]       bk_addr,
    output logic [15:0]       bk_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_GAP,
        RD_REQ,
        RD_GAP,
        PUSH,
        FIN
    } state_t;

`ifdef HUC3_RTC_CHECKSUM_EN
    localparam logic [2:0]  LAST_WR  = 3'd6;
    localparam logic [15:0] CHK_SEED = 16'hC3C3;
`else
    localparam logic [2:0]  LAST_WR  = 3'd5;
`endif

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] w_q [5];
    logic [15:0] w_d [5];
    logic        bad_q, bad_d;
    logic        err_q, err_d;
    logic [15:0] cur_word;
    logic [2:0]  push_last;

`ifdef HUC3_RTC_CHECKSUM_EN
    logic [15:0] csum;
    assign csum = w_q[0] ^ w_q[1] ^ w_q[2] ^ w_q[3] ^ w_q[4] ^ CHK_SEED;
`endif

    // Word 5 (the mapper trigger) is always zero, so only words 0..4 are stored.
    always_comb begin
        cur_word = '0;
        case (idx_q)
            3'd0:    cur_word = w_q[0];
            3'd1:    cur_word = w_q[1];
            3'd2:    cur_word = w_q[2];
            3'd3:    cur_word = w_q[3];
            3'd4:    cur_word = w_q[4];
`ifdef HUC3_RTC_CHECKSUM_EN
            3'd6:    cur_word = csum;
`endif
            default: cur_word = '0;
        endcase
    end

    assign push_last = bad_q ? 3'd4 : 3'd5;
    assign error     = err_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        w_d       = w_q;
        bad_d     = bad_q;
        err_d     = err_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        bk_rtc_wr = 1'b0;
        bk_addr   = '0;
        bk_data   = '0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_req) begin
                    state_d = RD_REQ;
                    idx_d   = '0;
                    bad_d   = 1'b0;
                end else if (save_req) begin
                    w_d[0]  = rtc_timestamp[15:0];
                    w_d[1]  = rtc_timestamp[31:16];
                    w_d[2]  = rtc_savedtime[15:0];
                    w_d[3]  = rtc_savedtime[31:16];
                    w_d[4]  = rtc_savedtime[47:32];
                    state_d = WR_REQ;
                    idx_d   = '0;
                end
            end

            WR_REQ: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = RTC_BASE + ADDR_W'(idx_q);
                mem_wdata = cur_word;
                if (mem_ack) begin
                    if (idx_q == LAST_WR) begin
                        state_d = FIN;
                        idx_d   = '0;
                    end else begin
                        state_d = WR_GAP;
                        idx_d   = 3'(idx_q + 3'd1);
                    end
                end
            end

            WR_GAP: begin
                busy    = 1'b1;
                state_d = WR_REQ;
            end

            RD_REQ: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = RTC_BASE + ADDR_W'(idx_q);
                if (mem_ack) begin
                    for (int unsigned k = 0; k < 5; k++) begin
                        if (idx_q == 3'(k)) w_d[k] = mem_rdata;
                    end
`ifdef HUC3_RTC_CHECKSUM_EN
                    // Word 5 is skipped on read: after word 4 the checksum word 6 is fetched.
                    if (idx_q == 3'd6) begin
                        if (mem_rdata != csum) begin
                            bad_d = 1'b1;
                            err_d = 1'b1;
                        end
                        state_d = PUSH;
                        idx_d   = '0;
                    end else if (idx_q == 3'd4) begin
                        state_d = RD_GAP;
                        idx_d   = 3'd6;
                    end else begin
                        state_d = RD_GAP;
                        idx_d   = 3'(idx_q + 3'd1);
                    end
`else
                    if (idx_q == 3'd4) begin
                        state_d = PUSH;
                        idx_d   = '0;
                    end else begin
                        state_d = RD_GAP;
                        idx_d   = 3'(idx_q + 3'd1);
                    end
`endif
                end
            end

            RD_GAP: begin
                busy    = 1'b1;
                state_d = RD_REQ;
            end

            PUSH: begin
                busy      = 1'b1;
                bk_rtc_wr = 1'b1;
                bk_addr   = 17'(idx_q);
                bk_data   = cur_word;
                if (idx_q == push_last) begin
                    state_d = FIN;
                    idx_d   = '0;
                end else begin
                    idx_d = 3'(idx_q + 3'd1);
                end
            end

            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            w_q     <= '{default: '0};
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            w_q     <= w_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_huc3_rtc_bk_ctrl.sv
// Directed bench for huc3_rtc_bk_ctrl: vector table of save/load transactions plus corner sequences.
`timescale 1ns/1ps

module tb_huc3_rtc_bk_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        save_req, load_req;
    logic [31:0] rtc_timestamp;
    logic [47:0] rtc_savedtime;
    logic        mem_req, mem_we;
    logic [16:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        bk_rtc_wr;
    logic [16:0] bk_addr;
    logic [15:0] bk_data;
    logic        busy, done, error;

    huc3_rtc_bk_ctrl #(.ADDR_W(17), .RTC_BASE(17'h0)) dut (
        .clk_sys(clk_sys), .reset(reset), .save_req(save_req), .load_req(load_req),
        .rtc_timestamp(rtc_timestamp), .rtc_savedtime(rtc_savedtime),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bk_rtc_wr(bk_rtc_wr),
        .bk_addr(bk_addr), .bk_data(bk_data), .busy(busy), .done(done), .error(error)
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;

    // Memory model, logs and protocol monitors (all updated on the falling edge).
    logic [15:0] mem [8];
    int          lat_v = 0;
    bit          spur = 1'b0;
    bit          clr = 1'b0;
    int          nc = 0;
    int          wait_cnt = 0;
    int          wr_cnt, rd_cnt, push_cnt, done_cnt, done_t, stab_err, b2b_err;
    logic [16:0] wr_addr [16];
    logic [15:0] wr_data [16];
    logic [16:0] rd_addr [16];
    logic [16:0] push_addr [16];
    logic [15:0] push_data [16];
    int          push_t [16];
    logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
    logic [16:0] prev_addr = '0;
    logic [15:0] prev_wdata = '0;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk_sys);
            nc++;
            if (clr) begin
                wr_cnt = 0; rd_cnt = 0; push_cnt = 0; done_cnt = 0;
                done_t = 0; stab_err = 0; b2b_err = 0;
            end
            if (bk_rtc_wr && push_cnt < 16) begin
                push_addr[push_cnt] = bk_addr;
                push_data[push_cnt] = bk_data;
                push_t[push_cnt]    = nc;
                push_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_t = nc;
            end
            if (mem_req && prev_req && prev_ack) b2b_err++;
            if (mem_req && prev_req && !prev_ack &&
                (mem_addr != prev_addr || mem_wdata != prev_wdata || mem_we != prev_we))
                stab_err++;
            if (mem_req && !reset) begin
                if (wait_cnt >= lat_v) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                    if (mem_we) begin
                        if (wr_cnt < 16) begin
                            wr_addr[wr_cnt] = mem_addr;
                            wr_data[wr_cnt] = mem_wdata;
                        end
                        wr_cnt++;
                    end else begin
                        mem_rdata = mem[mem_addr[2:0]];
                        if (rd_cnt < 16) rd_addr[rd_cnt] = mem_addr;
                        rd_cnt++;
                    end
                end else begin
                    mem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_ack  = spur;
                wait_cnt = 0;
            end
            prev_req   = mem_req;
            prev_ack   = mem_ack;
            prev_we    = mem_we;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk_sys);
            #1;
        end
    endtask

    task automatic clear_logs();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int k = 0; k < bound; k++) begin
            tick(1);
            if (done_cnt != 0) break;
        end
        tick(2);
    endtask

    typedef struct {
        bit              ld;
        bit              both;
        logic [31:0]     ts;
        logic [47:0]     st;
        int              lat;
        logic [5:0][15:0] w;
    } vec_t;

    vec_t vec [5];

    task automatic run_vec(input int i);
        int req_t;
        clear_logs();
        lat_v = vec[i].lat;
        for (int k = 0; k < 5; k++) mem[k] = vec[i].w[k];
        mem[5] = 16'hEEEE;
        mem[6] = 16'h7777;
        rtc_timestamp = vec[i].ts;
        rtc_savedtime = vec[i].st;
        save_req = !vec[i].ld || vec[i].both;
        load_req = vec[i].ld;
        req_t = nc;
        tick(1);
        save_req = 1'b0;
        load_req = 1'b0;
        rtc_timestamp = ~vec[i].ts;
        rtc_savedtime = ~vec[i].st;
        wait_done(400);
        chk($sformatf("v%0d done_once", i), 64'(done_cnt), 64'd1);
        chk($sformatf("v%0d no_back_to_back", i), 64'(b2b_err), 64'd0);
        chk($sformatf("v%0d idle_after", i), {busy, mem_req, bk_rtc_wr}, 64'd0);
        if (!vec[i].ld) begin
            chk($sformatf("v%0d wr_cnt", i), 64'(wr_cnt), 64'd6);
            chk($sformatf("v%0d rd_cnt", i), 64'(rd_cnt), 64'd0);
            for (int k = 0; k < 6; k++)
                chk($sformatf("v%0d wr%0d addr_data", i, k),
                    {wr_addr[k], wr_data[k]}, {17'(k), vec[i].w[k]});
            if (vec[i].lat == 0)
                chk($sformatf("v%0d save_latency", i), 64'(done_t - req_t), 64'd12);
        end else begin
            chk($sformatf("v%0d wr_cnt", i), 64'(wr_cnt), 64'd0);
            chk($sformatf("v%0d rd_cnt", i), 64'(rd_cnt), 64'd5);
            for (int k = 0; k < 5; k++)
                chk($sformatf("v%0d rd%0d addr", i, k), 64'(rd_addr[k]), 64'(k));
            chk($sformatf("v%0d push_cnt", i), 64'(push_cnt), 64'd6);
            for (int k = 0; k < 6; k++)
                chk($sformatf("v%0d push%0d addr_data", i, k),
                    {push_addr[k], push_data[k]}, {17'(k), vec[i].w[k]});
            chk($sformatf("v%0d push_contiguous", i), 64'(push_t[5] - push_t[0]), 64'd5);
            chk($sformatf("v%0d done_after_push", i), 64'(done_t - push_t[5]), 64'd1);
            if (vec[i].lat == 0)
                chk($sformatf("v%0d load_latency", i), 64'(done_t - req_t), 64'd16);
        end
    endtask

    initial begin
        vec[0] = '{ld: 1'b0, both: 1'b0, ts: 32'h1234_5678, st: 48'hABCD_0001_0203, lat: 0,
                   w: {16'h0000, 16'hABCD, 16'h0001, 16'h0203, 16'h1234, 16'h5678}};
        vec[1] = '{ld: 1'b0, both: 1'b0, ts: 32'hDEAD_BEEF, st: 48'h0000_FFFF_8001, lat: 1,
                   w: {16'h0000, 16'h0000, 16'hFFFF, 16'h8001, 16'hDEAD, 16'hBEEF}};
        vec[2] = '{ld: 1'b1, both: 1'b0, ts: 32'h0, st: 48'h0, lat: 2,
                   w: {16'h0000, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111}};
        vec[3] = '{ld: 1'b1, both: 1'b1, ts: 32'hCAFE_F00D, st: 48'h1357_2468_9BDF, lat: 0,
                   w: {16'h0000, 16'hFFFF, 16'hF0F0, 16'h0F0F, 16'h5A5A, 16'hA5A5}};
        vec[4] = '{ld: 1'b1, both: 1'b0, ts: 32'h0, st: 48'h0, lat: 0,
                   w: {16'h0000, 16'h8000, 16'h0008, 16'h0004, 16'h0002, 16'h0001}};
        for (int k = 0; k < 8; k++) mem[k] = '0;

        reset = 1'b1;
        save_req = 1'b0;
        load_req = 1'b0;
        rtc_timestamp = '0;
        rtc_savedtime = '0;
        tick(3);
        chk("reset_mem_outputs", {mem_req, mem_we, mem_addr, mem_wdata}, 64'd0);
        chk("reset_bk_outputs", {bk_rtc_wr, bk_addr, bk_data, busy, done, error}, 64'd0);
        reset = 1'b0;
        clear_logs();

        // Acks while no request is outstanding must not start anything.
        spur = 1'b1;
        tick(5);
        spur = 1'b0;
        tick(1);
        chk("spurious_ack_idle", {busy, mem_req, bk_rtc_wr, done}, 64'd0);
        chk("spurious_ack_no_done", 64'(done_cnt), 64'd0);

        for (int i = 0; i < 5; i++) run_vec(i);

        // Ack stall: 20 wait cycles per word during a save.
        clear_logs();
        lat_v = 20;
        rtc_timestamp = 32'h0F1E_2D3C;
        rtc_savedtime = 48'h4B5A_6978_8796;
        save_req = 1'b1;
        tick(1);
        save_req = 1'b0;
        wait_done(600);
        chk("stall_stable", 64'(stab_err), 64'd0);
        chk("stall_wr_cnt", 64'(wr_cnt), 64'd6);
        chk("stall_wr2", {wr_addr[2], wr_data[2]}, {17'd2, 16'h8796});
        chk("stall_wr4", {wr_addr[4], wr_data[4]}, {17'd4, 16'h4B5A});
        chk("stall_done", 64'(done_cnt), 64'd1);

        // Second save_req mid-save is dropped.
        clear_logs();
        lat_v = 0;
        rtc_timestamp = 32'h0BAD_F00D;
        rtc_savedtime = 48'h1111_2222_3333;
        save_req = 1'b1;
        tick(1);
        save_req = 1'b0;
        tick(3);
        rtc_timestamp = 32'h9999_9999;
        save_req = 1'b1;
        tick(1);
        save_req = 1'b0;
        wait_done(100);
        tick(20);
        chk("repulse_wr_cnt", 64'(wr_cnt), 64'd6);
        chk("repulse_done_cnt", 64'(done_cnt), 64'd1);
        chk("repulse_wr0", 64'(wr_data[0]), 64'h0000_F00D);

        // Reset during read of word 2 aborts silently.
        clear_logs();
        lat_v = 2;
        for (int k = 0; k < 5; k++) mem[k] = 16'(16'h0A00 + k);
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (mem_req && !mem_we && mem_addr == 17'd2) break;
            tick(1);
        end
        chk("abort_reached_rd2", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 17'd2});
        reset = 1'b1;
        tick(1);
        chk("abort_outputs", {mem_req, busy, bk_rtc_wr, done}, 64'd0);
        reset = 1'b0;
        tick(20);
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_no_push", 64'(push_cnt), 64'd0);
        chk("abort_rd_cnt", 64'(rd_cnt), 64'd2);

        clear_logs();
        lat_v = 0;
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
        wait_done(100);
        chk("reload_first_addr", 64'(rd_addr[0]), 64'd0);
        chk("reload_rd_cnt", 64'(rd_cnt), 64'd5);
        chk("reload_push_cnt", 64'(push_cnt), 64'd6);
        chk("reload_push3", {push_addr[3], push_data[3]}, {17'd3, 16'h0A03});
        chk("reload_push5", {push_addr[5], push_data[5]}, {17'd5, 16'h0000});
        chk("reload_done", 64'(done_cnt), 64'd1);
        chk("error_low", 64'(error), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
